// File: rtl/div_seq_ctrl_if.sv
// Execute-stage <-> divide sequencer handshake: opcode, operands, flush, and the
// stall/valid/result/busy responses.
interface div_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic [2:0]      alu_d_ops_i;
    logic [XLEN-1:0] operand_1_i;
    logic [XLEN-1:0] operand_2_i;
    logic            pipe_kill_i;
    logic            div_stall_o;
    logic            div_valid_o;
    logic [XLEN-1:0] div_result_o;
    logic            div_busy_o;

    modport master (
        output alu_d_ops_i, operand_1_i, operand_2_i, pipe_kill_i,
        input  div_stall_o, div_valid_o, div_result_o, div_busy_o
    );

    modport slave (
        input  alu_d_ops_i, operand_1_i, operand_2_i, pipe_kill_i,
        output div_stall_o, div_valid_o, div_result_o, div_busy_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divide/remainder sequencer for the M extension,
// with a single-cycle path for divide-by-zero and signed overflow.
module div_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    div_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;

    logic            req_s, is_signed_s, is_rem_s, sign1_s, sign2_s, div0_s, ovf_s;
    logic [XLEN-1:0] abs1_s, abs2_s;
    logic [XLEN:0]   partial_s, trial_s;
    logic            qbit_s;
    logic [XLEN-1:0] rem_nxt_s, quo_nxt_s, fix_q_s, fix_r_s;
    logic            stall_s, valid_s;

    // Opcode decode and operand conditioning; all four valid encodings have bit 2 set.
    always_comb begin
        req_s       = bus.alu_d_ops_i[2] & ~bus.pipe_kill_i;
        is_signed_s = ~bus.alu_d_ops_i[0];
        is_rem_s    = bus.alu_d_ops_i[1];
        sign1_s     = is_signed_s & bus.operand_1_i[XLEN-1];
        sign2_s     = is_signed_s & bus.operand_2_i[XLEN-1];
        abs1_s      = sign1_s ? neg2c(bus.operand_1_i) : bus.operand_1_i;
        abs2_s      = sign2_s ? neg2c(bus.operand_2_i) : bus.operand_2_i;
        div0_s      = (bus.operand_2_i == {XLEN{1'b0}});
        ovf_s       = is_signed_s
                    & (bus.operand_1_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.operand_2_i == {XLEN{1'b1}});
    end

    // One restoring step; the dividend register fills with quotient bits from the LSB.
    always_comb begin
        partial_s = {rem_q, dvd_q[XLEN-1]};
        trial_s   = partial_s - {1'b0, dvs_q};
        qbit_s    = ~trial_s[XLEN];
        rem_nxt_s = qbit_s ? trial_s[XLEN-1:0] : partial_s[XLEN-1:0];
        quo_nxt_s = {dvd_q[XLEN-2:0], qbit_s};
        fix_q_s   = neg_quo_q ? neg2c(quo_nxt_s) : quo_nxt_s;
        fix_r_s   = neg_rem_q ? neg2c(rem_nxt_s) : rem_nxt_s;
    end

    // Next-state and handshake outputs; kill overrides both iteration and completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        stall_s   = 1'b0;
        valid_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    stall_s   = 1'b1;
                    neg_quo_d = sign1_s ^ sign2_s;
                    neg_rem_d = sign1_s;
                    is_rem_d  = is_rem_s;
                    dvd_d     = abs1_s;
                    dvs_d     = abs2_s;
                    if (div0_s) begin
                        res_d   = is_rem_s ? bus.operand_1_i : {XLEN{1'b1}};
                        state_d = S_DONE;
                    end else if (ovf_s) begin
                        res_d   = is_rem_s ? {XLEN{1'b0}} : bus.operand_1_i;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN - 1);
                        rem_d   = {XLEN{1'b0}};
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_s = 1'b1;
                if (bus.pipe_kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    dvd_d = quo_nxt_s;
                    rem_d = rem_nxt_s;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        res_d   = is_rem_q ? fix_r_s : fix_q_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                valid_s = ~bus.pipe_kill_i;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            dvd_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            res_q     <= {XLEN{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign bus.div_stall_o  = stall_s;
    assign bus.div_valid_o  = valid_s;
    assign bus.div_result_o = res_q;
    assign bus.div_busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: reference quotient/remainder model feeding a
// result scoreboard, plus per-scenario latency, stall, kill and reset checks.
module tb_div_seq_ctrl;
    localparam int XLEN = 32;
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_seq_ctrl_if #(.XLEN(XLEN)) bus ();
    div_seq_ctrl #(.XLEN(XLEN), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    logic [31:0] last_res = 32'h0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIVU: model = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: model = (b == 32'h0) ? a : a % b;
            OP_DIV:  model = (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            OP_REM:  model = (b == 32'h0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: model = 32'h0;
        endcase
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        #1;
        if (bus.div_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: got %h, no result outstanding", bus.div_result_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.div_result_o !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got %h expected %h", bus.div_result_o, sb_exp);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        bus.alu_d_ops_i = op;
        bus.operand_1_i = a;
        bus.operand_2_i = b;
        if (push) begin
            exp_q.push_back(model(op, a, b));
            last_res = model(op, a, b);
        end
        #1;
    endtask

    task automatic wait_done(output int lat, output int stall_cnt);
        lat = -1;
        stall_cnt = (bus.div_stall_o === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.alu_d_ops_i = OP_NONE;
            #1;
            if (bus.div_valid_o === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.div_stall_o === 1'b1) stall_cnt++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.div_stall_o, bus.div_valid_o, bus.div_busy_o, bus.div_result_o} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b valid=%b busy=%b res=%h expected all 0",
                     bus.div_stall_o, bus.div_valid_o, bus.div_busy_o, bus.div_result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat, sc;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done(lat, sc);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        checks++;
        if (sc != 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", sc); end
        checks++;
        if (bus.div_result_o !== 32'h0000_000E || bus.div_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_done: got res=%h stall=%b expected res=0000000e stall=0", bus.div_result_o, bus.div_stall_o);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.div_stall_o !== 1'b0 || bus.div_busy_o !== 1'b0 || bus.div_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_after: got stall=%b busy=%b valid=%b expected 0 0 0",
                     bus.div_stall_o, bus.div_busy_o, bus.div_valid_o);
        end
    endtask

    task automatic test_signed();
        int lat, sc;
        logic [2:0] ops [4] = '{OP_REM, OP_DIV, OP_DIV, OP_REM};
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] bs [4] = '{32'h2, 32'h2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_done(lat, sc);
            checks++;
            if (lat != 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat); end
        end
    endtask

    task automatic test_fast_path();
        int lat, sc;
        logic [2:0] ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_done(lat, sc);
            checks++;
            if (lat != 1 || sc != 1) begin
                errors++;
                $display("FAIL fast_path[%0d]: got latency=%0d stall_cycles=%0d expected 1 1", i, lat, sc);
            end
        end
    endtask

    task automatic test_kill();
        issue(OP_DIV, 32'd50, 32'd5, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.alu_d_ops_i = OP_NONE;
            if (i == 10) bus.pipe_kill_i = 1'b1;
            #1;
        end
        checks++;
        if (bus.div_stall_o !== 1'b1 || bus.div_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy_cycle: got stall=%b valid=%b expected 1 0", bus.div_stall_o, bus.div_valid_o);
        end
        @(negedge clk);
        bus.pipe_kill_i = 1'b0;
        #1;
        checks++;
        if (bus.div_busy_o !== 1'b0 || bus.div_stall_o !== 1'b0 || bus.div_result_o !== last_res) begin
            errors++;
            $display("FAIL kill_after: got busy=%b stall=%b res=%h expected 0 0 %h",
                     bus.div_busy_o, bus.div_stall_o, bus.div_result_o, last_res);
        end
        repeat (40) @(negedge clk);
        // Kill landing on the completion cycle suppresses the valid pulse.
        issue(OP_DIVU, 32'd5, 32'd0, 1'b0);
        @(negedge clk);
        bus.alu_d_ops_i = OP_NONE;
        bus.pipe_kill_i = 1'b1;
        #1;
        checks++;
        if (bus.div_valid_o !== 1'b0 || bus.div_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL kill_done: got valid=%b busy=%b expected 0 1", bus.div_valid_o, bus.div_busy_o);
        end
        @(negedge clk);
        bus.alu_d_ops_i = OP_DIV;
        bus.operand_1_i = 32'd77;
        bus.operand_2_i = 32'd7;
        #1;
        checks++;
        if (bus.div_stall_o !== 1'b0 || bus.div_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_req: got stall=%b busy=%b expected 0 0", bus.div_stall_o, bus.div_busy_o);
        end
        @(negedge clk);
        bus.pipe_kill_i = 1'b0;
        bus.alu_d_ops_i = 3'b011;
        #1;
        checks++;
        if (bus.div_busy_o !== 1'b0 || bus.div_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op: got busy=%b stall=%b expected 0 0", bus.div_busy_o, bus.div_stall_o);
        end
        @(negedge clk);
        bus.alu_d_ops_i = OP_NONE;
        #1;
        checks++;
        if (bus.div_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op_busy: got busy=%b expected 0", bus.div_busy_o);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, sc;
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.alu_d_ops_i = OP_NONE;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.div_stall_o, bus.div_valid_o, bus.div_busy_o, bus.div_result_o} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_op: got stall=%b valid=%b busy=%b res=%h expected all 0",
                     bus.div_stall_o, bus.div_valid_o, bus.div_busy_o, bus.div_result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 32'h0;
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1);
        wait_done(lat, sc);
        checks++;
        if (lat != 33 || bus.div_result_o !== 32'd3) begin
            errors++;
            $display("FAIL reset_then_divu: got latency=%0d res=%h expected 33 00000003", lat, bus.div_result_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sc, exp_lat;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: begin b = 32'hFFFF_FFFF; if (i[0]) a = 32'h8000_0000; end
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            exp_lat = (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            issue(op, a, b, 1'b1);
            wait_done(lat, sc);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: op=%b a=%h b=%h got %0d expected %0d", i, op, a, b, lat, exp_lat);
            end
        end
    endtask

    initial begin
        bus.alu_d_ops_i = OP_NONE;
        bus.operand_1_i = 32'h0;
        bus.operand_2_i = 32'h0;
        bus.pipe_kill_i = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_fast_path();
        test_kill();
        test_reset_mid_op();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d results outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
